// File: rtl/free_list_if.sv
// Rename-stage free-list port bundle: rename/commit (master) drive requests,
// the free list (slave) returns the head register, its validity and the occupancy.
interface free_list_if #(
   parameter int PREG_WIDTH = 7
);
   logic                  alloc_req;
   logic [PREG_WIDTH-1:0] alloc_preg;
   logic                  alloc_valid;
   logic                  free_valid;
   logic [PREG_WIDTH-1:0] free_preg;
   logic                  is_branch_dispatch;
   logic                  branch_mispredict;
   logic [PREG_WIDTH:0]   free_count;
   logic                  fl_error;

   modport master (
      output alloc_req, free_valid, free_preg, is_branch_dispatch, branch_mispredict,
      input  alloc_preg, alloc_valid, free_count, fl_error
   );

   modport slave (
      input  alloc_req, free_valid, free_preg, is_branch_dispatch, branch_mispredict,
      output alloc_preg, alloc_valid, free_count, fl_error
   );
endinterface

// File: rtl/free_list.sv
// Physical register free list: circular FIFO of preg numbers with a single head
// checkpoint for mispredict recovery. Define FREE_LIST_CHECK_EN for the sticky fl_error.
module free_list #(
   parameter int PREG_WIDTH = 7,
   parameter int NUM_AREGS  = 32
) (
   input logic        clk,
   input logic        reset,
   free_list_if.slave fl
);
   localparam int NUM_PREGS = 2 ** PREG_WIDTH;
   localparam int NUM_INIT  = NUM_PREGS - NUM_AREGS;

   typedef logic [PREG_WIDTH:0]   ptr_t;
   typedef logic [PREG_WIDTH-1:0] preg_t;

   localparam ptr_t FULL_COUNT = ptr_t'(NUM_PREGS);

   preg_t mem [NUM_PREGS];
   ptr_t  head, tail, shadow_head, head_next;
   ptr_t  count;
   logic  do_pop, do_push, do_ckpt;

   always_comb begin
      count          = tail - head;
      fl.free_count  = count;
      fl.alloc_valid = (count != '0);
      fl.alloc_preg  = mem[head[PREG_WIDTH-1:0]];

      do_pop  = fl.alloc_req && fl.alloc_valid && !fl.branch_mispredict;
      do_push = fl.free_valid && (fl.free_preg != '0) && (count != FULL_COUNT);
      do_ckpt = fl.is_branch_dispatch && !fl.branch_mispredict;

      // Mispredict wins over this cycle's pop; the checkpoint sees the post-pop head.
      if (fl.branch_mispredict)
         head_next = shadow_head;
      else
         head_next = head + ptr_t'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the storage itself is reset because the initial free registers
         // (NUM_AREGS upward) must be present in the FIFO from the first cycle.
         for (int i = 0; i < NUM_PREGS; i++)
            mem[i] <= (i < NUM_INIT) ? preg_t'(NUM_AREGS + i) : '0;
         head        <= '0;
         shadow_head <= '0;
         tail        <= ptr_t'(NUM_INIT);
      end else begin
         if (do_push) begin
            mem[tail[PREG_WIDTH-1:0]] <= fl.free_preg;
            tail                      <= tail + ptr_t'(1);
         end
         head <= head_next;
         if (do_ckpt)
            shadow_head <= head_next;
      end
   end

`ifdef FREE_LIST_CHECK_EN
   logic err_event;
   logic fl_error_q;

   always_comb begin
      err_event = (fl.alloc_req && !fl.alloc_valid && !fl.branch_mispredict) ||
                  (fl.free_valid && (fl.free_preg == '0)) ||
                  (fl.free_valid && (count == FULL_COUNT));
   end

   always_ff @(posedge clk) begin
      if (reset)
         fl_error_q <= 1'b0;
      else if (err_event)
         fl_error_q <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset && err_event)
         $error("free_list: illegal alloc or free (count=%0d preg=%0d)", count, fl.free_preg);
   end

   assign fl.fl_error = fl_error_q;
`else
   assign fl.fl_error = 1'b0;
`endif
endmodule

// File: tb/tb_free_list.sv
// Randomized bench for free_list, checked against a queue-based model of the
// free pool, the allocations since the last checkpoint, and the committed live set.
module tb_free_list;
   localparam int PREG_WIDTH = 7;
   localparam int NUM_PREGS  = 128;
   localparam int NUM_AREGS  = 32;

   logic clk = 1'b0;
   logic reset;

   free_list_if #(.PREG_WIDTH(PREG_WIDTH)) fl_if ();

   free_list #(.PREG_WIDTH(PREG_WIDTH), .NUM_AREGS(NUM_AREGS)) dut (
      .clk   (clk),
      .reset (reset),
      .fl    (fl_if.slave)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model
   int free_q[$];   // registers in the free list, head first
   int spec_q[$];   // allocated since last checkpoint, oldest first
   int live_q[$];   // allocated and no longer recoverable; may be freed
   bit model_err;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      free_q.delete();
      spec_q.delete();
      live_q.delete();
      for (int r = NUM_AREGS; r < NUM_PREGS; r++) free_q.push_back(r);
      for (int r = 1; r < NUM_AREGS; r++) live_q.push_back(r);
      model_err = 1'b0;
   endfunction

   function automatic void forget(input int r);
      for (int i = 0; i < live_q.size(); i++)
         if (live_q[i] == r) begin live_q.delete(i); return; end
      for (int i = 0; i < spec_q.size(); i++)
         if (spec_q[i] == r) begin spec_q.delete(i); return; end
   endfunction

   function automatic void model_step(input bit areq, input bit fv, input int fp,
                                      input bit bd, input bit mp);
      int  size_pre  = free_q.size();
      bit  valid_pre = (size_pre != 0);
`ifdef FREE_LIST_CHECK_EN
      if ((areq && !valid_pre && !mp) || (fv && fp == 0) || (fv && size_pre == NUM_PREGS))
         model_err = 1'b1;
`endif
      if (mp) begin
         while (spec_q.size() != 0) free_q.push_front(spec_q.pop_back());
      end else begin
         if (areq && valid_pre) spec_q.push_back(free_q.pop_front());
         if (bd) begin
            foreach (spec_q[i]) live_q.push_back(spec_q[i]);
            spec_q.delete();
         end
      end
      if (fv && fp != 0 && size_pre != NUM_PREGS) begin
         forget(fp);
         free_q.push_back(fp);
      end
   endfunction

   // Check outputs against the model, drive one cycle of inputs, advance the model.
   task automatic cycle(input bit areq, input bit fv, input int fp,
                        input bit bd, input bit mp);
      fl_if.alloc_req          = areq;
      fl_if.free_valid         = fv;
      fl_if.free_preg          = PREG_WIDTH'(fp);
      fl_if.is_branch_dispatch = bd;
      fl_if.branch_mispredict  = mp;
      check("free_count", int'(fl_if.free_count), free_q.size());
      check("alloc_valid", int'(fl_if.alloc_valid), int'(free_q.size() != 0));
      if (free_q.size() != 0) check("alloc_preg", int'(fl_if.alloc_preg), free_q[0]);
      check("fl_error", int'(fl_if.fl_error), int'(model_err));
      @(posedge clk);
      model_step(areq, fv, fp, bd, mp);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset                    = 1'b1;
      fl_if.alloc_req          = 1'b0;
      fl_if.free_valid         = 1'b0;
      fl_if.free_preg          = '0;
      fl_if.is_branch_dispatch = 1'b0;
      fl_if.branch_mispredict  = 1'b0;
      @(posedge clk);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int fp;
      bit fv;
      do_reset();
      check("reset_count", int'(fl_if.free_count), 96);
      check("reset_preg", int'(fl_if.alloc_preg), 32);
      check("reset_err", int'(fl_if.fl_error), 0);

      // Drain: 32..127 in order, then empty
      for (int i = 0; i < 96; i++) cycle(1, 0, 0, 0, 0);
      check("drained_valid", int'(fl_if.alloc_valid), 0);
      check("drained_count", int'(fl_if.free_count), 0);

      // Free into empty list with a concurrent alloc: no bypass
      cycle(1, 1, 40, 0, 0);
      check("refill_valid", int'(fl_if.alloc_valid), 1);
      check("refill_preg", int'(fl_if.alloc_preg), 40);
      check("refill_count", int'(fl_if.free_count), 1);

      // Checkpoint at branch that allocates, then mispredict with concurrent free
      do_reset();
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 1, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 5, 0, 1);
      check("recover_preg", int'(fl_if.alloc_preg), 34);
      check("recover_count", int'(fl_if.free_count), 95);

      // Pop and push every cycle; pointers wrap
      do_reset();
      for (int i = 0; i < 200; i++) begin
         fp = live_q[$urandom_range(0, live_q.size() - 1)];
         cycle(1, 1, fp, 1, 0);
      end
      check("steady_count", int'(fl_if.free_count), 96);

      // Free of p0 is dropped
      cycle(0, 1, 0, 0, 0);
      check("p0_count", int'(fl_if.free_count), 96);
`ifdef FREE_LIST_CHECK_EN
      check("p0_err", int'(fl_if.fl_error), 1);
`else
      check("p0_err", int'(fl_if.fl_error), 0);
`endif

      // Reset mid-stream
      for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0);
      do_reset();
      check("midreset_count", int'(fl_if.free_count), 96);
      check("midreset_preg", int'(fl_if.alloc_preg), 32);
      check("midreset_err", int'(fl_if.fl_error), 0);

      // Random legal traffic: only committed (non-recoverable) registers are freed
      for (int i = 0; i < 3000; i++) begin
         fv = ($urandom_range(0, 99) < 45) && (live_q.size() != 0);
         fp = fv ? live_q[$urandom_range(0, live_q.size() - 1)] : 0;
         cycle($urandom_range(0, 99) < 55, fv, fp,
               $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
      end
      cycle(0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish (compared %0d)", n_cmp);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/free_list.md
# free_list

Physical register free list for the rename stage; counterpart to the rename map table. Supplies a fresh physical register (`alloc_preg`) for each renamed instruction that writes a non-zero `rd`, and takes back the previous mapping (`old_p_dest`) when the ROB commits that instruction. Implemented as a circular FIFO of physical register numbers. A single head-pointer checkpoint taken at branch dispatch restores speculatively allocated registers on a mispredict, in the same cycle the map table restores its shadow copy.

## Interface
- `PREG_WIDTH`, 7, physical register index width; `NUM_PREGS = 2**PREG_WIDTH` (128)
- `NUM_AREGS`, 32, architectural registers; p0..p(NUM_AREGS-1) are never initially free
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high
- `alloc_req`  in  1  rename consumes the head entry this cycle (`reg_write && rd != 0`)
- `alloc_preg`  out  PREG_WIDTH  head entry, combinational; meaningful only when `alloc_valid`
- `alloc_valid`  out  1  list not empty
- `free_valid`  in  1  commit returns a register
- `free_preg`  in  PREG_WIDTH  register being returned (`old_p_dest` of the committing instruction)
- `is_branch_dispatch`  in  1  checkpoint the head pointer
- `branch_mispredict`  in  1  restore the head pointer from the checkpoint
- `free_count`  out  PREG_WIDTH+1  number of free entries
- `fl_error`  out  1  sticky error flag; see Configuration

## Operation
- Storage: `mem[0..NUM_PREGS-1]` of PREG_WIDTH bits.
- Pointers: `head`, `tail` and `shadow_head`, each PREG_WIDTH+1 bits. The MSB is a wrap bit; the low bits index `mem`.
- `free_count = tail - head`, modulo 2^(PREG_WIDTH+1).
- `alloc_valid = (free_count != 0)`.
- Reset:
  - `mem[i] = NUM_AREGS + i` for `i < NUM_PREGS-NUM_AREGS`; all other entries 0.
  - `head = 0`, `shadow_head = 0`, `tail = NUM_PREGS-NUM_AREGS`.
  - Resulting outputs: `free_count = 96`, `alloc_valid = 1`, `alloc_preg = 32`, `fl_error = 0`.
- Pop: when `alloc_req && alloc_valid && !branch_mispredict`, then `head <= head+1`.
  - `alloc_req` with `!alloc_valid` is ignored; rename must stall.
- Push: when `free_valid && free_preg != 0 && free_count != NUM_PREGS`, then `mem[tail] <= free_preg` and `tail <= tail+1`.
  - A free of p0 is dropped, because x0 permanently maps to p0.
  - A free while full is dropped.
  - Push is accepted in every non-reset cycle, including mispredict cycles.
- Checkpoint: when `is_branch_dispatch && !branch_mispredict`, then `shadow_head <= head_next`, the head value after this cycle's pop. A JAL/JALR therefore excludes its own allocation from recovery, matching the map table's post-rename snapshot.
- Recovery: when `branch_mispredict`, then `head <= shadow_head`.
  - `alloc_req` and `is_branch_dispatch` are ignored in that cycle; the push still applies.
  - Entries between `shadow_head` and the old `head` are still intact, because registers allocated after the branch cannot commit before it resolves.
- Simultaneous pop and push: both apply, so `free_count` is unchanged.
- Empty plus push: the freed register is not bypassed. `alloc_valid` rises the next cycle.
- Reset asserted mid-operation overrides everything and restores the reset state.

## Timing
- `alloc_preg`, `alloc_valid` and `free_count` are combinational from registered state; zero-cycle lookup.
- All state updates take effect at the rising edge. A freed register becomes allocatable one cycle after `free_valid`.
- Recovery has single-cycle latency: the `alloc_preg` presented in the cycle after `branch_mispredict` is `mem[shadow_head]`.
- No internal FSM. Priority order: reset > mispredict > (pop, checkpoint). Push is independent of mispredict.

## Configuration
- `FREE_LIST_CHECK_EN` defined:
  - `fl_error` is set, and held until reset, on any of: `alloc_req && !alloc_valid && !branch_mispredict`; `free_valid && free_preg == 0`; `free_valid` while `free_count == NUM_PREGS`.
  - Simulation additionally issues `$error` on each such event.
- `FREE_LIST_CHECK_EN` undefined: `fl_error` is tied to 0, and the drop and ignore behaviour is otherwise identical.

## Test plan
- Reset, then hold `alloc_req` for 96 cycles -> `alloc_preg` = 32,33,...,127 in order; `free_count` reaches 0; `alloc_valid = 0`.
- Empty list, `free_valid` with `free_preg = 40` and `alloc_req` in the same cycle -> no pop that cycle; next cycle `alloc_valid = 1`, `alloc_preg = 40`, `free_count = 1`.
- After reset, allocate p32; then `is_branch_dispatch` with `alloc_req` (gets p33); allocate p34 and p35; then `branch_mispredict` together with `free_valid`/`free_preg = 5` -> next cycle `alloc_preg = 34`, `free_count = 95`.
- Simultaneous pop and push every cycle for 200 cycles -> `free_count` stays constant; pointers wrap with no lost or duplicated entries (scoreboard: every register 1..127 appears exactly once in free list ∪ live set).
- `free_valid` with `free_preg = 0` -> `free_count` unchanged; `fl_error = 1` only when `FREE_LIST_CHECK_EN` is defined.
- Assert `reset` mid-stream after 10 allocations -> next cycle `free_count = 96`, `alloc_preg = 32`, `fl_error = 0`.
